// File: rtl/rca_pipe_pkg.sv
// Shared defaults and the elaboration-time geometry check for the pipelined
// ripple-carry adder.
package rca_pipe_pkg;

    localparam int DEFAULT_WIDTH  = 64;
    localparam int DEFAULT_STAGES = 4;

    // True when WIDTH splits into STAGES equal, non-empty segments.
    function automatic bit width_ok(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end else begin
            return (width >= stages) && ((width % stages) == 0);
        end
    endfunction

endpackage

// File: rtl/rca_pipe_if.sv
// Operand/result handshake bundle of rca_pipe; master drives operands and
// out_ready, slave is the adder.
interface rca_pipe_if #(
    parameter int WIDTH = rca_pipe_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell used as the ripple element of every segment.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB so
// the top segment can derive signed overflow.
module rca_segment
    import rca_pipe_pkg::*;
#(
    parameter int SEG = DEFAULT_WIDTH / DEFAULT_STAGES
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);
    // Each bit owns its carry net so the chain is a set of distinct signals.
    for (genvar k = 0; k < SEG; k++) begin : g_bit
        logic ci_s;
        logic co_s;
        if (k == 0) begin : g_lsb
            assign ci_s = ci;
        end else begin : g_chain
            assign ci_s = g_bit[k-1].co_s;
        end
        full_adder u_fa (
            .a  (a[k]),
            .b  (b[k]),
            .ci (ci_s),
            .s  (s[k]),
            .co (co_s)
        );
    end

    assign co    = g_bit[SEG-1].co_s;
    assign c_msb = g_bit[SEG-1].ci_s;
endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: STAGES segments with skewed
// operand/result words and a per-stage ready chain that collapses bubbles.
module rca_pipe
    import rca_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic      clk,
    input  logic      rst,
    rca_pipe_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $fatal(1, "rca_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  word_r [STAGES];
    logic [WIDTH-1:0]  b_r    [STAGES];
    logic              ovf_r;

    logic [STAGES-1:0] rdy_s;
    logic [STAGES-1:0] nxt_v_s;
    logic [STAGES-1:0] nxt_c_s;
    logic              msb_c_s    [STAGES];
    logic [WIDTH-1:0]  nxt_word_s [STAGES];
    logic [WIDTH-1:0]  nxt_b_s    [STAGES];
    logic [WIDTH-1:0]  b_eff_s;
    logic              c0_s;
    logic              ovf_nxt_s;

    // Subtraction is a + ~b + !borrow_in.
    always_comb begin
        if (bus.sub) begin
            b_eff_s = ~bus.b;
            c0_s    = ~bus.cin;
        end else begin
            b_eff_s = bus.b;
            c0_s    = bus.cin;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] src_word_s;
        logic [WIDTH-1:0] word_s;
        logic [SEG-1:0]   seg_sum_s;
        logic             ci_s;

        if (i == 0) begin : g_head
            assign src_word_s = bus.a;
            assign nxt_b_s[i] = b_eff_s;
            assign ci_s       = c0_s;
            assign nxt_v_s[i] = bus.in_valid;
        end else begin : g_tail
            assign src_word_s = word_r[i-1];
            assign nxt_b_s[i] = b_r[i-1];
            assign ci_s       = c_r[i-1];
            assign nxt_v_s[i] = v_r[i-1];
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .a     (src_word_s[i*SEG +: SEG]),
            .b     (nxt_b_s[i][i*SEG +: SEG]),
            .ci    (ci_s),
            .s     (seg_sum_s),
            .co    (nxt_c_s[i]),
            .c_msb (msb_c_s[i])
        );

        // Splice this segment's sum over its slice of the a/result word.
        always_comb begin
            word_s                  = src_word_s;
            word_s[i*SEG +: SEG]    = seg_sum_s;
        end
        assign nxt_word_s[i] = word_s;

        // A stage can load unless it and every stage after it are full and stalled.
        assign rdy_s[i] = bus.out_ready | ~(&v_r[STAGES-1:i]);
    end

    assign ovf_nxt_s = msb_c_s[STAGES-1] ^ nxt_c_s[STAGES-1];

    // Stage registers: each stage takes its upstream content whenever its ready is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= {STAGES{1'b0}};
            c_r   <= {STAGES{1'b0}};
            ovf_r <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                word_r[i] <= {WIDTH{1'b0}};
                b_r[i]    <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy_s[i]) begin
                    v_r[i]    <= nxt_v_s[i];
                    c_r[i]    <= nxt_c_s[i];
                    word_r[i] <= nxt_word_s[i];
                    b_r[i]    <= nxt_b_s[i];
                end
            end
            if (rdy_s[STAGES-1]) begin
                ovf_r <= ovf_nxt_s;
            end
        end
    end

    assign bus.in_ready  = rdy_s[0];
    assign bus.out_valid = v_r[STAGES-1];
    assign bus.sum       = word_r[STAGES-1];
    assign bus.cout      = c_r[STAGES-1];
    assign bus.ovf       = ovf_r;
endmodule
